// File: rtl/write_output_pkg.sv
// Shared defaults for the write output buffer slice.
package write_output_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_LOG2_DEF = 3;

endpackage

// File: rtl/write_output_buffer_if.sv
// Push/pop handshake and status bundle between a producer and the write output buffer.
interface write_output_buffer_if
    import write_output_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) ();

    logic                  TICK_IN;
    logic                  WR_EN;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  CLEAR_FLAGS;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  VALID_OUT;
    logic                  FULL;
    logic                  EMPTY;
    logic [DEPTH_LOG2:0]   COUNT;
    logic                  OVERFLOW;
    logic                  UNDERRUN;

    modport master (
        output TICK_IN, WR_EN, DATA_IN, CLEAR_FLAGS,
        input  DATA_OUT, VALID_OUT, FULL, EMPTY, COUNT, OVERFLOW, UNDERRUN
    );

    modport slave (
        input  TICK_IN, WR_EN, DATA_IN, CLEAR_FLAGS,
        output DATA_OUT, VALID_OUT, FULL, EMPTY, COUNT, OVERFLOW, UNDERRUN
    );

endinterface

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the divided write-clock level; the falling edge is ignored.
module tick_edge_detect (
    input  logic IN_50Mhz,
    input  logic RESET_N,
    input  logic TICK_IN,
    output logic TICK_RISE
);

    logic tick_d;

    // Delay the tick level by one cycle to compare against the current level.
    always_ff @(posedge IN_50Mhz or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= TICK_IN;
        end
    end

    assign TICK_RISE = TICK_IN & ~tick_d;

endmodule

// File: rtl/write_output_buffer.sv
// Write output buffer: a small FIFO filled by the producer and drained one word
// per rising edge of the divided tick. Optional macro WRITE_OUTPUT_UNDERRUN_ZERO_EN
// makes an underrun tick emit a zero word (silence) instead of holding the output.
module write_output_buffer
    import write_output_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                 IN_50Mhz,
    input  logic                 RESET_N,
    write_output_buffer_if.slave bus
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam int                  CW        = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] COUNT_MAX = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_q;
    logic                  empty_q;
    logic                  overflow_q;
    logic                  underrun_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  tick_rise;
    logic                  do_pop;
    logic                  do_push;
    logic                  ovf_set;
    logic                  und_set;

    tick_edge_detect u_tick_edge_detect (
        .IN_50Mhz  (IN_50Mhz),
        .RESET_N   (RESET_N),
        .TICK_IN   (bus.TICK_IN),
        .TICK_RISE (tick_rise)
    );

    // A pop in the same cycle frees a slot, so a push while full is accepted then.
    always_comb begin
        do_pop     = tick_rise & ~empty_q;
        und_set    = tick_rise & empty_q;
        do_push    = bus.WR_EN & (~full_q | do_pop);
        ovf_set    = bus.WR_EN & full_q & ~do_pop;
        count_next = count_q;
        case ({do_push, do_pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // Storage array; contents are don't-care after reset since pointers restart.
    always_ff @(posedge IN_50Mhz) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.DATA_IN;
        end
    end

    // Pointers, occupancy, status flags and the registered output word.
    always_ff @(posedge IN_50Mhz or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                data_q  <= mem[rd_ptr];
                valid_q <= 1'b1;
                rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
            end
`ifdef WRITE_OUTPUT_UNDERRUN_ZERO_EN
            else if (und_set) begin
                data_q  <= '0;
                valid_q <= 1'b1;
            end
`endif
            count_q <= count_next;
            full_q  <= (count_next == COUNT_MAX);
            empty_q <= (count_next == '0);
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (bus.CLEAR_FLAGS) begin
                overflow_q <= 1'b0;
            end
            if (und_set) begin
                underrun_q <= 1'b1;
            end else if (bus.CLEAR_FLAGS) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign bus.DATA_OUT  = data_q;
    assign bus.VALID_OUT = valid_q;
    assign bus.FULL      = full_q;
    assign bus.EMPTY     = empty_q;
    assign bus.COUNT     = count_q;
    assign bus.OVERFLOW  = overflow_q;
    assign bus.UNDERRUN  = underrun_q;

endmodule
